// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module      : uart_tx_buffered
// Description : UART transmitter with a one-entry holding register. Frames are
//               start(0), 8 data bits LSB first, even parity, stop(1). Bit
//               period is clks_per_bit+1 clocks, latched at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered (
  input  logic       clk,
  input  logic       rst,           // synchronous, active-low
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [9:0] clks_per_bit,
  output logic       TX_out,
  output logic       busy,
  output logic       eoc_flag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     state_q;
  logic [9:0] cnt_q;        // cycle position within the current bit
  logic [9:0] cnt_d;
  logic [9:0] cpb_q;        // bit period latched at frame start
  logic [2:0] bit_idx_q;    // data bit being sent
  logic [7:0] shift_q;
  logic       parity_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       tx_q;
  logic       busy_q;
  logic       eoc_q;

  logic       handshake;
  logic       bit_end;
  logic       stop_end;
  logic       hold_write;

  assign data_ready = !hold_full_q;
  assign handshake  = data_valid && !hold_full_q;
  assign bit_end    = (cnt_q == cpb_q);
  assign cnt_d      = bit_end ? 10'd0 : cnt_q + 10'd1;
  assign stop_end   = (state_q == S_STOP) && bit_end;
  // A handshake while a frame is running parks the byte, except on the final
  // stop edge where the byte goes straight into the shift register instead.
  assign hold_write = handshake && (state_q != S_IDLE) && !stop_end;

  assign TX_out   = tx_q;
  assign busy     = busy_q;
  assign eoc_flag = eoc_q;

  // Frame sequencer, holding register and registered line/status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 10'd0;
      cpb_q       <= 10'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      eoc_q       <= 1'b0;
    end else begin
      eoc_q <= 1'b0;

      if (hold_write) begin
        hold_q      <= data_in;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= 10'd0;
          if (handshake) begin
            shift_q   <= data_in;
            parity_q  <= ^data_in;
            cpb_q     <= clks_per_bit;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_START;
          end
        end

        S_START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
          end
        end

        S_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              tx_q    <= parity_q;
              state_q <= S_PARITY;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end

        S_PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            eoc_q <= 1'b1;
            if (hold_full_q) begin
              // Queued byte starts with no idle gap.
              shift_q     <= hold_q;
              parity_q    <= ^hold_q;
              cpb_q       <= clks_per_bit;
              hold_full_q <= 1'b0;
              bit_idx_q   <= 3'd0;
              tx_q        <= 1'b0;
              state_q     <= S_START;
            end else if (handshake) begin
              shift_q   <= data_in;
              parity_q  <= ^data_in;
              cpb_q     <= clks_per_bit;
              bit_idx_q <= 3'd0;
              tx_q      <= 1'b0;
              state_q   <= S_START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 10'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Scoreboard bench for uart_tx_buffered. Accepted bytes are
//               queued; a line monitor decodes each frame against the ideal
//               bit sequence and checks busy/eoc_flag/data_ready every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [9:0] clks_per_bit = 10'd9;
  logic       TX_out;
  logic       busy;
  logic       eoc_flag;

  uart_tx_buffered dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .clks_per_bit (clks_per_bit),
    .TX_out       (TX_out),
    .busy         (busy),
    .eoc_flag     (eoc_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: bytes accepted, in order; rd_idx marks the next one to appear.
  logic [7:0] exp_q[$];
  int         rd_idx = 0;

  // Values of the stimulus seen by the DUT at the most recent rising edge.
  logic [9:0] cpb_at_edge = 10'd0;
  logic       rst_at_edge = 1'b0;
  always @(posedge clk) begin
    cpb_at_edge <= clks_per_bit;
    rst_at_edge <= rst;
  end

  // Monitor state
  bit         in_frame = 1'b0;
  int         k = 0;
  int         flen = 0;
  int         bad_k = -1;
  logic       bad_got = 1'b0;
  logic [7:0] cur = 8'h00;
  logic [9:0] fcpb = 10'd0;

  // Ideal line level for bit slot idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else if (idx == 9) return ^b;
    else               return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic monitor_step();
    logic exp_eoc;
    if (!rst_at_edge) begin
      in_frame = 1'b0;
      rd_idx   = exp_q.size();
      chk("reset_tx", TX_out, 1);
      chk("reset_busy", busy, 0);
      chk("reset_ready", data_ready, 1);
      chk("reset_eoc", eoc_flag, 0);
    end else begin
      exp_eoc = 1'b0;
      if (in_frame && k == flen) begin
        in_frame = 1'b0;
        exp_eoc  = 1'b1;
        checks++;
        if (bad_k >= 0) begin
          errors++;
          $display("FAIL frame byte=%02h cpb=%0d sample=%0d: got %0b expected %0b",
                   cur, fcpb, bad_k, bad_got, ~bad_got);
        end
      end
      if (!in_frame) begin
        if (rd_idx < exp_q.size()) begin
          chk("start_bit", TX_out, 0);
          cur      = exp_q[rd_idx];
          rd_idx++;
          fcpb     = cpb_at_edge;
          flen     = 11 * (int'(fcpb) + 1);
          k        = 0;
          bad_k    = -1;
          in_frame = 1'b1;
        end else begin
          chk("idle_tx", TX_out, 1);
        end
      end
      if (in_frame) begin
        if (bad_k < 0 && TX_out !== frame_bit(cur, k / (int'(fcpb) + 1))) begin
          bad_k   = k;
          bad_got = TX_out;
        end
        k++;
      end
      chk("eoc_flag", eoc_flag, exp_eoc);
      chk("busy", busy, in_frame);
      chk("data_ready", data_ready, (rd_idx >= exp_q.size()));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    data_in    = b;
    data_valid = 1'b1;
    while (!data_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!data_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout byte=%02h: got data_ready=0 expected 1 within 3000 cycles", b);
      data_valid = 1'b0;
      return;
    end
    checks++;
    @(posedge clk);
    exp_q.push_back(b);
    #1;
    data_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rd_idx < exp_q.size() || in_frame) && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (rd_idx < exp_q.size() || in_frame) begin
      errors++;
      $display("FAIL idle_timeout: got %0d pending frames expected 0", exp_q.size() - rd_idx);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          monitor_step();
        end
      end
      begin
        // Reset
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();

        // Single frames at 10-cycle bits
        clks_per_bit = 10'd9;
        send(8'hA5);
        wait_idle();
        send(8'h07);
        wait_idle();
        send(8'h00);
        wait_idle();
        repeat (3) tick();

        // Back-to-back through the holding register
        send(8'hA5);
        repeat (30) tick();
        send(8'h3C);
        send(8'h81);
        wait_idle();
        repeat (3) tick();

        // Reset mid-DATA with the holding register full
        send(8'h55);
        send(8'hAA);
        repeat (40) tick();
        do_reset();
        repeat (300) tick();

        // Bit period changed mid-frame
        clks_per_bit = 10'd9;
        send(8'hC3);
        repeat (20) tick();
        clks_per_bit = 10'd4;
        wait_idle();
        send(8'h3C);
        wait_idle();

        // Random bytes, gaps and bit periods (including 0)
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0)
            clks_per_bit = 10'($urandom_range(0, 7));
          repeat ($urandom_range(0, 3)) tick();
          send(8'($urandom));
          if ($urandom_range(0, 9) == 0) wait_idle();
        end
        wait_idle();
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

endmodule

`default_nettype wire
